// File: rtl/bus_slot_scheduler_if.sv
// Bus slot scheduler signal bundle: CPU bus timing, DMA requester port and RAM mux controls.
interface bus_slot_scheduler_if;
  logic [15:0] bus_addr;
  logic        cpu_clken;
  logic        phi2;
  logic        dma_req;
  logic [15:0] dma_addr;
  logic        dma_we;
  logic [7:0]  dma_wdata;
  logic [7:0]  ram_dout;
  logic        mem_sel_dma;
  logic        mem_we_dma;
  logic        dma_ack;
  logic        dma_err;
  logic [7:0]  dma_rdata;

  // System side: drives the CPU address, DMA request and RAM data; consumes the timing outputs.
  modport master (
    output bus_addr, dma_req, dma_addr, dma_we, dma_wdata, ram_dout,
    input  cpu_clken, phi2, mem_sel_dma, mem_we_dma, dma_ack, dma_err, dma_rdata
  );

  // Scheduler side.
  modport slave (
    input  bus_addr, dma_req, dma_addr, dma_we, dma_wdata, ram_dout,
    output cpu_clken, phi2, mem_sel_dma, mem_we_dma, dma_ack, dma_err, dma_rdata
  );
endinterface

// File: rtl/bus_slot_scheduler.sv
// Bus slot scheduler for the 65C02 system: splits bus time into SLOT_LEN-clk slots owned by the
// CPU or a RAM-only DMA requester, generates cpu_clken/phi2, inserts wait slots for slow regions
// and bounds DMA bursts so the CPU always gets a slot between bursts.
module bus_slot_scheduler #(
  parameter int unsigned SLOT_LEN      = 4,
  parameter int unsigned EXT_WAIT      = 1,
  parameter int unsigned ROM_WAIT      = 0,
  parameter int unsigned DMA_MAX_BURST = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  bus_slot_scheduler_if.slave  bus
);

  localparam int unsigned CTR_W   = $clog2(SLOT_LEN);
  localparam int unsigned WAIT_W  = 3;
  localparam int unsigned BURST_W = 5;

  localparam logic [CTR_W-1:0]   CTR_LAST  = CTR_W'(SLOT_LEN - 1);
  localparam logic [CTR_W-1:0]   CTR_PRE   = CTR_W'(SLOT_LEN - 2);
  localparam logic [CTR_W-1:0]   CTR_HALF  = CTR_W'(SLOT_LEN / 2);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(DMA_MAX_BURST);

  typedef enum logic [1:0] {
    ST_CPU  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DMA  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CTR_W-1:0]   ctr;
  logic [CTR_W-1:0]   ctr_nxt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [WAIT_W-1:0]  addr_wait;
  logic [WAIT_W-1:0]  eff_wait;
  logic [BURST_W-1:0] burst;
  logic [BURST_W-1:0] burst_inc;
  logic               slot_end;
  logic               pre_end;
  logic               cpu_done;
  logic               dma_more;
  logic               dma_bad;
  logic               unused_bits;

  // Only bit 15 of the DMA address matters here; write data is muxed onto RAM at the top level.
  assign unused_bits = ^{bus.dma_addr[14:0], bus.dma_wdata};

  // Region decode of the CPU address into the number of extra wait slots it needs.
  always_comb begin
    addr_wait = '0;
    if (bus.bus_addr[15:14] == 2'b11) begin
      addr_wait = WAIT_W'(ROM_WAIT);
    end else if (bus.bus_addr[15] &&
                 (bus.bus_addr[15:4] != 12'h800) &&
                 (bus.bus_addr[15:4] != 12'h880)) begin
      addr_wait = WAIT_W'(EXT_WAIT);
    end
  end

  // Slot position, CPU-cycle completion and next-slot ownership.
  always_comb begin
    slot_end  = (ctr == CTR_LAST);
    pre_end   = (ctr == CTR_PRE);
    ctr_nxt   = slot_end ? '0 : ctr + CTR_W'(1);
    // On the decode clk the freshly decoded wait count is not yet in wait_cnt.
    eff_wait  = ((state == ST_CPU) && (ctr == '0)) ? addr_wait : wait_cnt;
    cpu_done  = ((state == ST_CPU) && (eff_wait == '0)) ||
                ((state == ST_WAIT) && (wait_cnt == WAIT_W'(1)));
    burst_inc = burst + BURST_W'(1);
    dma_more  = bus.dma_req && (burst_inc < BURST_MAX);
    dma_bad   = bus.dma_addr[15];
    state_nxt = state;
    if (slot_end) begin
      case (state)
        ST_CPU, ST_WAIT: begin
          // A completed CPU cycle satisfies any forced CPU slot, so DMA may follow at once.
          if (cpu_done) state_nxt = bus.dma_req ? ST_DMA : ST_CPU;
          else          state_nxt = ST_WAIT;
        end
        ST_DMA:  state_nxt = dma_more ? ST_DMA : ST_CPU;
        default: state_nxt = ST_CPU;
      endcase
    end
  end

  // Slot FSM, wait/burst counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_CPU;
      ctr             <= '0;
      wait_cnt        <= '0;
      burst           <= '0;
      bus.cpu_clken   <= 1'b0;
      bus.phi2        <= 1'b0;
      bus.mem_sel_dma <= 1'b0;
      bus.mem_we_dma  <= 1'b0;
      bus.dma_ack     <= 1'b0;
      bus.dma_err     <= 1'b0;
      bus.dma_rdata   <= '0;
    end else begin
      state           <= state_nxt;
      ctr             <= ctr_nxt;
      bus.phi2        <= (ctr_nxt >= CTR_HALF);
      bus.mem_sel_dma <= (state_nxt == ST_DMA);
      // Pulses are set one clk early so they are high during the last clk of the slot.
      bus.cpu_clken   <= pre_end && cpu_done;
      bus.dma_ack     <= pre_end && (state == ST_DMA);
      bus.dma_err     <= pre_end && (state == ST_DMA) && dma_bad;
      bus.mem_we_dma  <= pre_end && (state == ST_DMA) && bus.dma_we && !dma_bad;

      if ((state == ST_CPU) && (ctr == '0)) wait_cnt <= addr_wait;

      if (slot_end) begin
        case (state)
          ST_CPU, ST_WAIT: begin
            if (cpu_done) begin
              burst    <= '0;
              wait_cnt <= '0;
            end else if (state == ST_WAIT) begin
              wait_cnt <= wait_cnt - WAIT_W'(1);
            end
          end
          ST_DMA: begin
            burst <= burst_inc;
            if (dma_bad)          bus.dma_rdata <= 8'hFF;
            else if (!bus.dma_we) bus.dma_rdata <= bus.ram_dout;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
